// File: rtl/ch_config_regs.sv
// -----------------------------------------------------------------------------
// ch_config_regs
//
// Per-channel configuration register bank for one DDS channel. Byte writes
// from the bus interface land in shadow registers. A commit request copies the
// whole shadow set into the active outputs in a single clock edge, so the DDS
// never sees a half-updated parameter set.
//
// Build option:
//   COMMIT_SYNC_EN  When defined, a pending commit waits for SYNC_STROBE.
//                   The transfer then happens on the edge after the strobe
//                   is sampled. When undefined, the transfer happens on the
//                   edge after the commit write, and SYNC_STROBE is unused.
//
// Ports:
//   CLK_LOW         system clock, rising edge
//   RST_N           asynchronous active-low reset
//   CONFIG_WE       single-cycle byte-write strobe
//   CONFIG_ADDR     write register address
//   CONFIG_DATA     write data byte
//   READ_REG_ADDR   read register address
//   SYNC_STROBE     waveform-period sync pulse (COMMIT_SYNC_EN only)
//   READ_BACK_DATA  registered read data, one cycle after READ_REG_ADDR
//   FREQ_WORD       active frequency tuning word
//   PHASE_WORD      active phase offset
//   AMPL            active amplitude
//   OFFSET          active DC offset
//   WAVE_SEL        active waveform select
//   OUT_EN          channel output enable (written directly, no shadow)
//   CFG_UPDATE      one-cycle pulse after each shadow-to-active transfer
// -----------------------------------------------------------------------------
module ch_config_regs #(
   parameter logic [7:0]  CH_ID      = 8'h01,
   parameter logic [13:0] AMPL_RST   = 14'h1FFF,
   parameter logic [13:0] OFFSET_RST = 14'h2000
) (
   input  logic        CLK_LOW,
   input  logic        RST_N,
   input  logic        CONFIG_WE,
   input  logic [7:0]  CONFIG_ADDR,
   input  logic [7:0]  CONFIG_DATA,
   input  logic [7:0]  READ_REG_ADDR,
   input  logic        SYNC_STROBE,
   output logic [7:0]  READ_BACK_DATA,
   output logic [31:0] FREQ_WORD,
   output logic [15:0] PHASE_WORD,
   output logic [13:0] AMPL,
   output logic [13:0] OFFSET,
   output logic [3:0]  WAVE_SEL,
   output logic        OUT_EN,
   output logic        CFG_UPDATE
);

   // ST_ARMED is reachable only in the synchronised build. It marks the
   // cycle between a sampled SYNC_STROBE and the transfer edge.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_ARMED = 2'd2
   } state_t;

   state_t      state_q, state_d;

   logic [31:0] freq_sh_q,   freq_sh_d;
   logic [15:0] phase_sh_q,  phase_sh_d;
   logic [13:0] ampl_sh_q,   ampl_sh_d;
   logic [13:0] offset_sh_q, offset_sh_d;
   logic [3:0]  wave_sh_q,   wave_sh_d;

   logic [31:0] freq_q,      freq_d;
   logic [15:0] phase_q,     phase_d;
   logic [13:0] ampl_q,      ampl_d;
   logic [13:0] offset_q,    offset_d;
   logic [3:0]  wave_q,      wave_d;

   logic        out_en_q,     out_en_d;
   logic        cfg_update_q, cfg_update_d;
   logic        pending_q,    pending_d;
   logic [7:0]  rd_data_q,    rd_data_d;

   logic        shadow_wr;
   logic        commit_wr;
   logic        xfer;

`ifndef COMMIT_SYNC_EN
   logic        unused_sync;
   assign unused_sync = SYNC_STROBE;
`endif

   assign shadow_wr = CONFIG_WE && (CONFIG_ADDR <= 8'h0A);
   assign commit_wr = CONFIG_WE && (CONFIG_ADDR == 8'h0C) && CONFIG_DATA[0];

   always_comb begin
      state_d      = state_q;
      freq_sh_d    = freq_sh_q;
      phase_sh_d   = phase_sh_q;
      ampl_sh_d    = ampl_sh_q;
      offset_sh_d  = offset_sh_q;
      wave_sh_d    = wave_sh_q;
      freq_d       = freq_q;
      phase_d      = phase_q;
      ampl_d       = ampl_q;
      offset_d     = offset_q;
      wave_d       = wave_q;
      out_en_d     = out_en_q;
      cfg_update_d = 1'b0;
      pending_d    = pending_q;
      rd_data_d    = 8'h00;
      xfer         = 1'b0;

      // Commit sequencing. A commit write that arrives while a request is
      // already outstanding is absorbed, because the state stays non-idle.
      case (state_q)
         ST_IDLE: begin
            if (commit_wr) state_d = ST_REQ;
         end
`ifdef COMMIT_SYNC_EN
         ST_REQ: begin
            if (SYNC_STROBE) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            xfer    = 1'b1;
            state_d = ST_IDLE;
         end
`else
         ST_REQ: begin
            xfer    = 1'b1;
            state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      // The transfer copies the shadow values held before this edge. A shadow
      // write on the same edge is kept for the next commit.
      if (xfer) begin
         freq_d       = freq_sh_q;
         phase_d      = phase_sh_q;
         ampl_d       = ampl_sh_q;
         offset_d     = offset_sh_q;
         wave_d       = wave_sh_q;
         cfg_update_d = 1'b1;
      end

      if (CONFIG_WE) begin
         case (CONFIG_ADDR)
            8'h00:   freq_sh_d[7:0]     = CONFIG_DATA;
            8'h01:   freq_sh_d[15:8]    = CONFIG_DATA;
            8'h02:   freq_sh_d[23:16]   = CONFIG_DATA;
            8'h03:   freq_sh_d[31:24]   = CONFIG_DATA;
            8'h04:   phase_sh_d[7:0]    = CONFIG_DATA;
            8'h05:   phase_sh_d[15:8]   = CONFIG_DATA;
            8'h06:   ampl_sh_d[7:0]     = CONFIG_DATA;
            8'h07:   ampl_sh_d[13:8]    = CONFIG_DATA[5:0];
            8'h08:   offset_sh_d[7:0]   = CONFIG_DATA;
            8'h09:   offset_sh_d[13:8]  = CONFIG_DATA[5:0];
            8'h0A:   wave_sh_d          = CONFIG_DATA[3:0];
            8'h0B:   out_en_d           = CONFIG_DATA[0];
            default: ;
         endcase
      end

      // A shadow write wins over the clear, so data written at the transfer
      // edge is still flagged as uncommitted.
      if (shadow_wr) begin
         pending_d = 1'b1;
      end else if (xfer) begin
         pending_d = 1'b0;
      end

      case (READ_REG_ADDR)
         8'h00:   rd_data_d = freq_sh_q[7:0];
         8'h01:   rd_data_d = freq_sh_q[15:8];
         8'h02:   rd_data_d = freq_sh_q[23:16];
         8'h03:   rd_data_d = freq_sh_q[31:24];
         8'h04:   rd_data_d = phase_sh_q[7:0];
         8'h05:   rd_data_d = phase_sh_q[15:8];
         8'h06:   rd_data_d = ampl_sh_q[7:0];
         8'h07:   rd_data_d = {2'b00, ampl_sh_q[13:8]};
         8'h08:   rd_data_d = offset_sh_q[7:0];
         8'h09:   rd_data_d = {2'b00, offset_sh_q[13:8]};
         8'h0A:   rd_data_d = {4'b0000, wave_sh_q};
         8'h0B:   rd_data_d = {7'b0000000, out_en_q};
         8'h0C:   rd_data_d = {7'b0000000, (state_q != ST_IDLE)};
         8'h0D:   rd_data_d = {7'b0000000, pending_q};
         8'h0E:   rd_data_d = CH_ID;
         default: rd_data_d = 8'h00;
      endcase
   end

   always_ff @(posedge CLK_LOW or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= ST_IDLE;
         freq_sh_q    <= 32'h0;
         phase_sh_q   <= 16'h0;
         ampl_sh_q    <= AMPL_RST;
         offset_sh_q  <= OFFSET_RST;
         wave_sh_q    <= 4'h0;
         freq_q       <= 32'h0;
         phase_q      <= 16'h0;
         ampl_q       <= AMPL_RST;
         offset_q     <= OFFSET_RST;
         wave_q       <= 4'h0;
         out_en_q     <= 1'b0;
         cfg_update_q <= 1'b0;
         pending_q    <= 1'b0;
         rd_data_q    <= 8'h00;
      end else begin
         state_q      <= state_d;
         freq_sh_q    <= freq_sh_d;
         phase_sh_q   <= phase_sh_d;
         ampl_sh_q    <= ampl_sh_d;
         offset_sh_q  <= offset_sh_d;
         wave_sh_q    <= wave_sh_d;
         freq_q       <= freq_d;
         phase_q      <= phase_d;
         ampl_q       <= ampl_d;
         offset_q     <= offset_d;
         wave_q       <= wave_d;
         out_en_q     <= out_en_d;
         cfg_update_q <= cfg_update_d;
         pending_q    <= pending_d;
         rd_data_q    <= rd_data_d;
      end
   end

   assign READ_BACK_DATA = rd_data_q;
   assign FREQ_WORD      = freq_q;
   assign PHASE_WORD     = phase_q;
   assign AMPL           = ampl_q;
   assign OFFSET         = offset_q;
   assign WAVE_SEL       = wave_q;
   assign OUT_EN         = out_en_q;
   assign CFG_UPDATE     = cfg_update_q;

endmodule

// File: tb/tb_ch_config_regs.sv
// -----------------------------------------------------------------------------
// tb_ch_config_regs
//
// Directed bench for ch_config_regs. Each read request pushes its expected byte
// and each commit pushes its expected active set. A monitor process pops and
// compares entries when read data becomes valid or when CFG_UPDATE pulses.
// -----------------------------------------------------------------------------
module tb_ch_config_regs;

   logic        CLK_LOW = 1'b0;
   logic        RST_N = 1'b0;
   logic        CONFIG_WE = 1'b0;
   logic [7:0]  CONFIG_ADDR = 8'h00;
   logic [7:0]  CONFIG_DATA = 8'h00;
   logic [7:0]  READ_REG_ADDR = 8'h00;
   logic        SYNC_STROBE = 1'b0;
   logic [7:0]  READ_BACK_DATA;
   logic [31:0] FREQ_WORD;
   logic [15:0] PHASE_WORD;
   logic [13:0] AMPL;
   logic [13:0] OFFSET;
   logic [3:0]  WAVE_SEL;
   logic        OUT_EN;
   logic        CFG_UPDATE;

   ch_config_regs dut (
      .CLK_LOW        (CLK_LOW),
      .RST_N          (RST_N),
      .CONFIG_WE      (CONFIG_WE),
      .CONFIG_ADDR    (CONFIG_ADDR),
      .CONFIG_DATA    (CONFIG_DATA),
      .READ_REG_ADDR  (READ_REG_ADDR),
      .SYNC_STROBE    (SYNC_STROBE),
      .READ_BACK_DATA (READ_BACK_DATA),
      .FREQ_WORD      (FREQ_WORD),
      .PHASE_WORD     (PHASE_WORD),
      .AMPL           (AMPL),
      .OFFSET         (OFFSET),
      .WAVE_SEL       (WAVE_SEL),
      .OUT_EN         (OUT_EN),
      .CFG_UPDATE     (CFG_UPDATE)
   );

   // ---------------- clock ----------------
   always #5 CLK_LOW = ~CLK_LOW;

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  rd_exp_q[$];
   logic [79:0] upd_exp_q[$];   // {freq, phase, ampl, offset, wave}
   logic        rd_strobe = 1'b0;
   logic        rd_vld_q = 1'b0;

   always @(posedge CLK_LOW) rd_vld_q <= rd_strobe;

   // ---------------- monitor ----------------
   always @(negedge CLK_LOW) begin
      logic [7:0]  rexp;
      logic [79:0] uexp;
      logic [79:0] uact;
      if (rd_vld_q) begin
         checks++;
         if (rd_exp_q.size() == 0) begin
            errors++;
            $display("FAIL readback: data %02h with nothing expected", READ_BACK_DATA);
         end else begin
            rexp = rd_exp_q.pop_front();
            if (READ_BACK_DATA !== rexp) begin
               errors++;
               $display("FAIL readback: got %02h expected %02h", READ_BACK_DATA, rexp);
            end
         end
      end
      if (CFG_UPDATE !== 1'b0) begin
         checks++;
         uact = {FREQ_WORD, PHASE_WORD, AMPL, OFFSET, WAVE_SEL};
         if (upd_exp_q.size() == 0) begin
            errors++;
            $display("FAIL cfg_update: unexpected pulse, active set %020h", uact);
         end else begin
            uexp = upd_exp_q.pop_front();
            if (uact !== uexp) begin
               errors++;
               $display("FAIL cfg_update: active set %020h expected %020h", uact, uexp);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge CLK_LOW);
      CONFIG_WE = 1'b0;
      rd_strobe = 1'b0;
   endtask

   task automatic set_wr(input logic [7:0] a, input logic [7:0] d);
      CONFIG_WE   = 1'b1;
      CONFIG_ADDR = a;
      CONFIG_DATA = d;
   endtask

   task automatic set_rd(input logic [7:0] a, input logic [7:0] e);
      READ_REG_ADDR = a;
      rd_strobe     = 1'b1;
      rd_exp_q.push_back(e);
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      set_wr(a, d);
      tick();
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] e);
      set_rd(a, e);
      tick();
   endtask

   task automatic expect_upd(input logic [31:0] f, input logic [15:0] p,
                             input logic [13:0] am, input logic [13:0] o,
                             input logic [3:0] w);
      upd_exp_q.push_back({f, p, am, o, w});
   endtask

   // Issues a commit. On return, the next rising edge is the transfer edge.
   task automatic go_commit();
      set_wr(8'h0C, 8'h01);
      tick();
`ifdef COMMIT_SYNC_EN
      SYNC_STROBE = 1'b1;
      tick();
      SYNC_STROBE = 1'b0;
`endif
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      RST_N = 1'b0;
      repeat (3) @(negedge CLK_LOW);
      chk("rst freq",   FREQ_WORD, 32'h0);
      chk("rst phase",  {16'h0, PHASE_WORD}, 32'h0);
      chk("rst ampl",   {18'h0, AMPL}, 32'h1FFF);
      chk("rst offset", {18'h0, OFFSET}, 32'h2000);
      chk("rst wave",   {28'h0, WAVE_SEL}, 32'h0);
      chk("rst out_en", {31'h0, OUT_EN}, 32'h0);
      chk("rst cfg_update", {31'h0, CFG_UPDATE}, 32'h0);
      chk("rst readback", {24'h0, READ_BACK_DATA}, 32'h0);
      RST_N = 1'b1;
      tick();

      rd(8'h0E, 8'h01);
      rd(8'h07, 8'h1F);
      rd(8'h09, 8'h20);

      // Frequency bytes, then commit.
      wr(8'h00, 8'h78);
      wr(8'h01, 8'h56);
      wr(8'h02, 8'h34);
      wr(8'h03, 8'h12);
      chk("freq before commit", FREQ_WORD, 32'h0);
      rd(8'h0D, 8'h01);
      expect_upd(32'h12345678, 16'h0, 14'h1FFF, 14'h2000, 4'h0);
      go_commit();
      chk("freq before transfer edge", FREQ_WORD, 32'h0);
      tick();
      chk("freq after transfer", FREQ_WORD, 32'h12345678);
      chk("cfg_update pulse", {31'h0, CFG_UPDATE}, 32'h1);
      rd(8'h0D, 8'h00);
      chk("cfg_update one cycle", {31'h0, CFG_UPDATE}, 32'h0);
      rd(8'h00, 8'h78);
      rd(8'h03, 8'h12);

      // Amplitude with ignored top bits.
      wr(8'h06, 8'hFF);
      wr(8'h07, 8'hFF);
      expect_upd(32'h12345678, 16'h0, 14'h3FFF, 14'h2000, 4'h0);
      go_commit();
      tick();
      chk("ampl full scale", {18'h0, AMPL}, 32'h3FFF);
      rd(8'h07, 8'h3F);
      rd(8'h06, 8'hFF);

      // Unmapped address.
      wr(8'h55, 8'hAB);
      rd(8'h55, 8'h00);
      rd(8'h0D, 8'h00);
      chk("ampl after unmapped write", {18'h0, AMPL}, 32'h3FFF);

      // OUT_EN is applied directly.
      wr(8'h0B, 8'h01);
      chk("out_en direct", {31'h0, OUT_EN}, 32'h1);
      rd(8'h0B, 8'h01);

      // Offset packing.
      wr(8'h08, 8'h34);
      wr(8'h09, 8'hFF);
      rd(8'h09, 8'h3F);
      rd(8'h08, 8'h34);

      // A shadow write on the transfer edge misses the transfer.
      expect_upd(32'h12345678, 16'h0, 14'h3FFF, 14'h3F34, 4'h0);
      go_commit();
      set_wr(8'h0A, 8'h03);
      tick();
      chk("wave kept old", {28'h0, WAVE_SEL}, 32'h0);
      chk("offset committed", {18'h0, OFFSET}, 32'h3F34);
      rd(8'h0D, 8'h01);
      rd(8'h0A, 8'h03);
      expect_upd(32'h12345678, 16'h0, 14'h3FFF, 14'h3F34, 4'h3);
      go_commit();
      tick();
      chk("wave second commit", {28'h0, WAVE_SEL}, 32'h3);
      rd(8'h0D, 8'h00);

      // A read in the same cycle as a write returns the old value.
      set_wr(8'h04, 8'hCD);
      set_rd(8'h04, 8'h00);
      tick();
      rd(8'h04, 8'hCD);
      rd(8'h05, 8'h00);

      // Second commit write at the transfer edge is absorbed.
      expect_upd(32'h12345678, 16'h00CD, 14'h3FFF, 14'h3F34, 4'h3);
      go_commit();
      set_wr(8'h0C, 8'h01);
      tick();
      chk("phase committed", {16'h0, PHASE_WORD}, 32'h00CD);
      tick();
      tick();
      rd(8'h0C, 8'h00);

      // Commit write while CFG_UPDATE is high gives a second pulse.
      expect_upd(32'h12345678, 16'h00CD, 14'h3FFF, 14'h3F34, 4'h3);
      expect_upd(32'h12345678, 16'h00CD, 14'h3FFF, 14'h3F34, 4'h3);
      go_commit();
      tick();
      chk("first back-to-back pulse", {31'h0, CFG_UPDATE}, 32'h1);
      go_commit();
      tick();
      chk("second back-to-back pulse", {31'h0, CFG_UPDATE}, 32'h1);

      // Commit with bit0 clear does nothing.
      wr(8'h0C, 8'h00);
      tick();
      tick();
      rd(8'h0C, 8'h00);
      chk("no pulse on bit0=0", {31'h0, CFG_UPDATE}, 32'h0);

      // Commit status reads 1 while a request is outstanding.
      expect_upd(32'h12345678, 16'h00CD, 14'h3FFF, 14'h3F34, 4'h3);
      go_commit();
      set_rd(8'h0C, 8'h01);
      tick();
      tick();

`ifdef COMMIT_SYNC_EN
      // A strobe coinciding with the commit write does not count.
      wr(8'h00, 8'h11);
      expect_upd(32'h12345611, 16'h00CD, 14'h3FFF, 14'h3F34, 4'h3);
      set_wr(8'h0C, 8'h01);
      SYNC_STROBE = 1'b1;
      tick();
      SYNC_STROBE = 1'b0;
      repeat (10) tick();
      chk("sync hold freq", FREQ_WORD, 32'h12345678);
      rd(8'h0C, 8'h01);
      SYNC_STROBE = 1'b1;
      tick();
      SYNC_STROBE = 1'b0;
      chk("sync no pulse yet", {31'h0, CFG_UPDATE}, 32'h0);
      tick();
      chk("sync pulse", {31'h0, CFG_UPDATE}, 32'h1);
      chk("sync freq", FREQ_WORD, 32'h12345611);
      SYNC_STROBE = 1'b1;
      tick();
      tick();
      SYNC_STROBE = 1'b0;
      rd(8'h0C, 8'h00);
`endif

      // Reset during a pending commit aborts it.
      set_wr(8'h0C, 8'h01);
      tick();
      RST_N = 1'b0;
      tick();
      tick();
      RST_N = 1'b1;
      repeat (4) tick();
      chk("abort ampl", {18'h0, AMPL}, 32'h1FFF);
      chk("abort freq", FREQ_WORD, 32'h0);
      chk("abort out_en", {31'h0, OUT_EN}, 32'h0);
      chk("abort cfg_update", {31'h0, CFG_UPDATE}, 32'h0);
      rd(8'h0C, 8'h00);
      rd(8'h0D, 8'h00);
      rd(8'h07, 8'h1F);

      repeat (3) tick();
      chk("read queue drained", rd_exp_q.size(), 32'h0);
      chk("update queue drained", upd_exp_q.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
